// File: rtl/toggle_pulse_rx_if.sv
// Event handshake between toggle_pulse_rx and its consumer.
// The receiver drives out_valid/pend_cnt and samples out_ready.
interface toggle_pulse_rx_if #(
    parameter int PEND_WIDTH = 4
);
    logic                  out_valid;
    logic                  out_ready;
    logic [PEND_WIDTH-1:0] pend_cnt;

    modport master (
        output out_valid,
        output pend_cnt,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  pend_cnt,
        output out_ready
    );
endinterface

// File: rtl/toggle_pulse_rx.sv
// Destination side of a toggle pulse crossing: one event per level change,
// queued in a saturating credit counter and acknowledged by a return toggle.
module toggle_pulse_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int PEND_WIDTH  = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    toggle_pulse_rx_if.master    evt,
    input  logic                 toggle,
    output logic                 ack_toggle,
    output logic                 overflow,
    input  logic                 overflow_clr,
    output logic [CNT_WIDTH-1:0] edge_cnt,
    output logic                 warm
);

    localparam int WARM_W = $clog2(SYNC_STAGES + 2);
    localparam logic [WARM_W-1:0]     WARM_END = WARM_W'(SYNC_STAGES + 1);
    localparam logic [WARM_W-1:0]     WARM_ONE = WARM_W'(1);
    localparam logic [PEND_WIDTH-1:0] PEND_ONE = PEND_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_last;
    logic                   toggle_d;
    logic [WARM_W-1:0]      warm_cnt;
    logic [PEND_WIDTH-1:0]  pend_q;
    logic [PEND_WIDTH-1:0]  pend_nxt;
    logic                   edge_det;
    logic                   accept;
    logic                   full;
    logic                   ovf_set;

    assign sync_last = sync[SYNC_STAGES-1];
    assign edge_det  = (sync_last ^ toggle_d) & warm;
    assign full      = &pend_q;

    // out_valid comes straight from the credit register, no input path.
    assign evt.out_valid = |pend_q;
    assign evt.pend_cnt  = pend_q;
    assign accept        = evt.out_valid & evt.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync     <= '0;
            toggle_d <= 1'b0;
        end else begin
            sync     <= {sync[SYNC_STAGES-2:0], toggle};
            toggle_d <= sync_last;
        end
    end

    // toggle_d tracks during warm-up, so a line already high is absorbed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            warm_cnt <= '0;
            warm     <= 1'b0;
        end else begin
            if (warm_cnt != WARM_END) begin
                warm_cnt <= warm_cnt + WARM_ONE;
            end
            if (warm_cnt == WARM_END) begin
                warm <= 1'b1;
            end
        end
    end

    always_comb begin
        pend_nxt = pend_q;
        ovf_set  = 1'b0;
        unique case ({edge_det, accept})
            2'b10: begin
                if (full) begin
                    ovf_set = 1'b1;
                end else begin
                    pend_nxt = pend_q + PEND_ONE;
                end
            end
            2'b01:   pend_nxt = pend_q - PEND_ONE;
            default: pend_nxt = pend_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q     <= '0;
            ack_toggle <= 1'b0;
        end else begin
            pend_q <= pend_nxt;
            if (accept) begin
                ack_toggle <= ~ack_toggle;
            end
        end
    end

    // A new drop wins over a clear issued in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt <= '0;
        end else if (edge_det) begin
            edge_cnt <= edge_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_toggle_pulse_rx.sv
// Bench for toggle_pulse_rx: directed scenarios plus random traffic,
// checked every cycle against an event-arrival reference model.
module tb_toggle_pulse_rx;

    localparam int S    = 2;
    localparam int PW   = 4;
    localparam int CW   = 16;
    localparam int FULL = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          toggle;
    logic          ready;
    logic          overflow_clr;
    logic          ack_toggle;
    logic          overflow;
    logic [CW-1:0] edge_cnt;
    logic          warm;

    toggle_pulse_rx_if #(.PEND_WIDTH(PW)) bus ();
    assign bus.out_ready = ready;

    toggle_pulse_rx #(
        .SYNC_STAGES(S),
        .PEND_WIDTH (PW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .evt         (bus),
        .toggle      (toggle),
        .ack_toggle  (ack_toggle),
        .overflow    (overflow),
        .overflow_clr(overflow_clr),
        .edge_cnt    (edge_cnt),
        .warm        (warm)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference: a flip before edge k is an event arriving at edge k+S,
    // counted only once warm-up (S+2 edges after release) has passed.
    int n;
    bit arr[int];
    int m_pend;
    int m_edges;
    bit m_ack;
    bit m_ovf;
    int gap;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("out_valid", 32'(bus.out_valid), 32'(m_pend != 0));
        chk("pend_cnt", 32'(bus.pend_cnt), 32'(m_pend));
        chk("ack_toggle", 32'(ack_toggle), 32'(m_ack));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("edge_cnt", 32'(edge_cnt), 32'(m_edges));
        chk("warm", 32'(warm), 32'(n >= S + 2));
    endtask

    task automatic model_reset();
        n       = 0;
        arr.delete();
        m_pend  = 0;
        m_edges = 0;
        m_ack   = 1'b0;
        m_ovf   = 1'b0;
    endtask

    task automatic step();
        bit ev, acc, drop;
        if (rst) begin
            model_reset();
        end else begin
            n++;
            ev = arr.exists(n) && (n - 1 >= S + 2);
            if (arr.exists(n)) arr.delete(n);
            acc  = (m_pend != 0) && ready;
            drop = ev && !acc && (m_pend == FULL);
            if (ev) m_edges = (m_edges + 1) % (1 << CW);
            if (ev && !acc && !drop) m_pend++;
            if (!ev && acc) m_pend--;
            if (drop) m_ovf = 1'b1;
            else if (overflow_clr) m_ovf = 1'b0;
            if (acc) m_ack = ~m_ack;
        end
        @(posedge clk);
        #1;
        check_all();
        gap++;
    endtask

    task automatic flip();
        toggle = ~toggle;
        arr[n + 1 + S] = 1'b1;
        gap = 0;
    endtask

    task automatic steps(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    initial begin
        rst          = 1'b1;
        toggle       = 1'b1;
        ready        = 1'b0;
        overflow_clr = 1'b0;
        gap          = 0;
        model_reset();
        steps(3);
        // toggle held high through release must be absorbed
        rst = 1'b0;
        steps(S + 4);

        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            flip();
            steps(6);
        end
        chk("ack_after_3", 32'(ack_toggle), 32'd1);
        chk("edges_after_3", 32'(edge_cnt), 32'd3);

        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            flip();
            steps(2);
        end
        steps(S + 2);
        chk("pend_5", 32'(bus.pend_cnt), 32'd5);
        ready = 1'b1;
        steps(7);

        ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            flip();
            steps(2);
        end
        steps(S + 2);
        chk("pend_full", 32'(bus.pend_cnt), 32'(FULL));
        chk("ovf_set", 32'(overflow), 32'd1);
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        steps(2);
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // edge and accept land on the same edge while full
        flip();
        steps(S);
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("full_simul_pend", 32'(bus.pend_cnt), 32'(FULL));
        chk("full_simul_ovf", 32'(overflow), 32'd0);
        steps(3);

        ready = 1'b1;
        steps(FULL + 2);
        ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            flip();
            steps(2);
        end
        steps(S + 2);
        chk("pend_7", 32'(bus.pend_cnt), 32'd7);

        // asynchronous reset between clock edges
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        steps(2);
        rst = 1'b0;
        steps(S + 6);
        ready = 1'b1;
        flip();
        steps(S + 4);

        for (int i = 0; i < 500; i++) begin
            ready        = 1'($urandom_range(0, 1));
            overflow_clr = ($urandom_range(0, 15) == 0);
            if (gap >= 2 && $urandom_range(0, 2) == 0) flip();
            step();
        end
        overflow_clr = 1'b0;
        ready        = 1'b1;
        steps(FULL + S + 4);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/toggle_pulse_rx.md
Name: toggle_pulse_rx

Overview:
- Destination-side partner of the toggle-based pulse crossing. The source side flips a level line once per event; this block recovers one event per level change on its own clock.
- Synchronizes the incoming toggle, detects level changes, and queues events in a small credit counter. Events are presented on a valid/ready handshake.
- Returns an acknowledge toggle so the source domain can apply flow control. Keeps a sticky overflow flag and a free-running event count for debug.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops on the toggle input; legal values are 2 or more.
PEND_WIDTH, 4, width of the pending-event counter; maximum backlog is 2^PEND_WIDTH-1 events.
CNT_WIDTH, 16, width of the total-event counter.

Ports:
clk  input  1  single clock for the block.
rst  input  1  reset, asynchronous and active-high; clears all state.
toggle  input  1  toggle line from the other clock domain; each level change is one event.
out_valid  output  1  at least one event is pending.
out_ready  input  1  consumer accepts one event when it is high in the same cycle as out_valid.
pend_cnt  output  PEND_WIDTH  number of events currently pending.
ack_toggle  output  1  flips once per accepted event; routed back to the source domain.
overflow  output  1  sticky flag: an event was dropped because pend_cnt was full.
overflow_clr  input  1  clears overflow synchronously.
edge_cnt  output  CNT_WIDTH  total detected events, including dropped ones; wraps modulo 2^CNT_WIDTH.
warm  output  1  high once the warm-up period after reset is complete.

Behaviour:
- Reset values: sync chain = 0, toggle_d = 0, pend_cnt = 0, out_valid = 0, ack_toggle = 0, overflow = 0, edge_cnt = 0, warm = 0, warm-up counter = 0.
- Synchronizer:
  - sync[0] samples toggle on every rising clk edge.
  - sync[i] takes sync[i-1].
  - sync_last = sync[SYNC_STAGES-1].
  - toggle_d registers sync_last every cycle, including during warm-up.
- Edge detect: edge = (sync_last XOR toggle_d) AND warm.
- Warm-up:
  - The counter runs from 0 to SYNC_STAGES+1; warm sets when it reaches that value and then holds.
  - While warm = 0, edges are ignored and only toggle_d tracks sync_last. A toggle that is already 1 at reset release therefore produces no event.
- Latency: if toggle changes before rising edge k (and warm = 1), sync_last updates at edge k+SYNC_STAGES-1 and pend_cnt increments at edge k+SYNC_STAGES. out_valid is high in the following cycle.
- out_valid = (pend_cnt != 0), registered-equivalent (derived from a register with no combinational path from the inputs).
- Accept = out_valid AND out_ready.
- pend_cnt update rules:
  - edge only: +1.
  - accept only: -1.
  - edge and accept in the same cycle: unchanged.
  - neither: unchanged.
- Full case (pend_cnt = 2^PEND_WIDTH-1), edge and no accept: the event is dropped, pend_cnt holds, overflow sets at the same edge.
- Full case with edge and accept together: counts as a simultaneous edge/accept, so pend_cnt is unchanged and there is no overflow.
- overflow priority: set beats overflow_clr in the same cycle. Otherwise overflow_clr clears overflow at the next edge.
- ack_toggle inverts at the clock edge of every accept.
- edge_cnt increments on every edge (dropped events included) and wraps from all-ones to 0.
- out_ready while out_valid = 0: ignored; nothing changes.
- Reset mid-operation:
  - Pending events are discarded and ack_toggle returns to 0. The source side must be reset together with this block.
  - Warm-up restarts, so a toggle line stuck at 1 is absorbed without generating an event.
- Back-to-back: toggle changes in consecutive source cycles are only guaranteed to be detected if each level is held at least 2 clk periods. Faster changes are out of contract.

Test Plan:
- Hold toggle = 1 through reset and release -> warm rises after SYNC_STAGES+2 edges; out_valid stays 0 and edge_cnt = 0.
- After warm-up, out_ready = 1; flip toggle 3 times, 6 cycles apart -> 3 single-cycle out_valid pulses, each SYNC_STAGES+1 cycles after its flip; ack_toggle ends at 1; edge_cnt = 3.
- out_ready = 0; flip toggle 5 times -> pend_cnt reaches 5; then out_ready = 1 -> out_valid high for exactly 5 cycles; ack_toggle flips 5 times; pend_cnt = 0.
- PEND_WIDTH = 4, out_ready = 0; flip toggle 16 times -> pend_cnt = 15, overflow = 1, edge_cnt = 16; pulse overflow_clr -> overflow = 0 while pend_cnt stays 15.
- pend_cnt = 15, edge arrives in the same cycle as an accept -> pend_cnt stays 15 and overflow stays 0.
- Assert rst while pend_cnt = 7 -> all outputs return to their reset values immediately (asynchronously); no event emitted after release until a new toggle flip occurs after warm-up.
